// File: rtl/seq_det_pkg.sv
// Shared types and limits for the parameterised serial pattern detector.
// Holds the detector FSM encoding and the legal pattern-length bounds.
package seq_det_pkg;

    localparam int PAT_LEN_MIN = 2;
    localparam int PAT_LEN_MAX = 16;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } seq_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
// Holds at all-ones once reached until cleared or reset.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/param_seq_detector.sv
// Serial bit-pattern detector with loadable pattern, optional overlap
// and a saturating match counter.
module param_seq_detector
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN     = 4,
    parameter int                 CNT_W       = 8,
    parameter logic [PAT_LEN-1:0] DEFAULT_PAT = 4'b1011
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       data_in,
    input  logic                       valid_in,
    input  logic [PAT_LEN-1:0]         pattern_in,
    input  logic                       pattern_load,
    input  logic                       overlap_en,
    input  logic                       clear_cnt,
    output logic                       detection_out,
    output logic [CNT_W-1:0]           match_count,
    output logic [$clog2(PAT_LEN+1)-1:0] fill_level
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_LEN);

    seq_state_e         state_q, state_d;
    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               det_q, det_d;

    logic [PAT_LEN-1:0] hist_shift;
    logic [FILL_W-1:0]  fill_nxt;
    logic               match;

    always_comb begin
        hist_shift = {hist_q[PAT_LEN-2:0], data_in};
        fill_nxt   = fill_q;
        unique case (state_q)
            ST_FILL:  fill_nxt = fill_q + 1'b1;
            ST_ARMED: fill_nxt = fill_q;
        endcase
    end

    // A match needs a full window, so stale history never fires after a flush.
    assign match = valid_in && !pattern_load
                   && (hist_shift == pat_q) && (fill_nxt == FULL);

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        det_d   = 1'b0;

        if (pattern_load) begin
            pat_d   = pattern_in;
            hist_d  = '0;
            fill_d  = '0;
            state_d = ST_FILL;
        end else if (valid_in) begin
            if (match) begin
                det_d = 1'b1;
                if (overlap_en) begin
                    hist_d  = hist_shift;
                    fill_d  = FULL;
                    state_d = ST_ARMED;
                end else begin
                    hist_d  = '0;
                    fill_d  = '0;
                    state_d = ST_FILL;
                end
            end else begin
                hist_d  = hist_shift;
                fill_d  = fill_nxt;
                state_d = (fill_nxt == FULL) ? ST_ARMED : ST_FILL;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FILL;
            pat_q   <= DEFAULT_PAT;
            hist_q  <= '0;
            fill_q  <= '0;
            det_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            det_q   <= det_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .clr   (clear_cnt),
        .count (match_count)
    );

    assign detection_out = det_q;
    assign fill_level    = fill_q;

endmodule
